// File: rtl/alu_selftest.sv
// Built-in self-test engine for the lx32 ALU: applies a fixed 9-vector table and checks the results.
// Optional build macro ALU_SELFTEST_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
package lx32_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
endpackage

package branches_pkg;
  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } branch_op_e;
endpackage

module alu_selftest
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int FAIL_CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [FAIL_CNT_W-1:0] fail_count_o,
  output logic [3:0]            first_fail_idx_o,
  output logic [WIDTH-1:0]      src_a_o,
  output logic [WIDTH-1:0]      src_b_o,
  output alu_op_e               alu_control_o,
  output logic                  is_branch_o,
  output branch_op_e            branch_op_o,
  input  logic [WIDTH-1:0]      alu_result_i,
  input  logic                  alu_branch_true_i
);

  if (WIDTH != 32) begin : g_bad_width
    $error("alu_selftest: WIDTH must be 32, the vector table is 32-bit");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_selftest: SETTLE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [FAIL_CNT_W-1:0] FAIL_ONE = 1;
  localparam logic [3:0]            IDX_NONE = 4'hF;
  localparam logic [3:0]            IDX_LAST = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          op;
    logic             is_br;
    branch_op_e       br_op;
    logic [WIDTH-1:0] exp_res;
    logic             exp_br;
  } vec_t;

  function automatic vec_t vec_at(input logic [3:0] i);
    vec_t v;
    case (i)
      4'd0:    v = '{32'h0000000A, 32'h00000005, ALU_ADD,  1'b0, BR_EQ,  32'h0000000F, 1'b0};
      4'd1:    v = '{32'h0000000A, 32'h00000005, ALU_SUB,  1'b0, BR_EQ,  32'h00000005, 1'b0};
      4'd2:    v = '{32'hFFFFFFFF, 32'h00000001, ALU_SLT,  1'b0, BR_EQ,  32'h00000001, 1'b0};
      4'd3:    v = '{32'hFFFFFFFF, 32'h00000001, ALU_SLTU, 1'b0, BR_EQ,  32'h00000000, 1'b0};
      4'd4:    v = '{32'hF0000000, 32'hF0000000, ALU_SLTU, 1'b1, BR_EQ,  32'h00000000, 1'b1};
      4'd5:    v = '{32'hFFFFFFFF, 32'h00000001, ALU_SLT,  1'b1, BR_LT,  32'h00000001, 1'b1};
      4'd6:    v = '{32'hFFFFFFFF, 32'h00000001, ALU_SLTU, 1'b1, BR_GEU, 32'h00000000, 1'b1};
      4'd7:    v = '{32'h80000000, 32'h00000001, ALU_SRA,  1'b0, BR_EQ,  32'hC0000000, 1'b0};
      4'd8:    v = '{32'h80000000, 32'h00000001, ALU_SRL,  1'b0, BR_EQ,  32'h40000000, 1'b0};
      default: v = '{'0, '0, ALU_ADD, 1'b0, BR_EQ, '0, 1'b0};
    endcase
    return v;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FAIL_CNT_W-1:0]   fail_q, fail_d;
  logic [3:0]              ffi_q, ffi_d;
  logic                    pass_q, pass_d;
  logic [WIDTH-1:0]        src_a_q, src_a_d, src_b_q, src_b_d;
  alu_op_e                 op_q, op_d;
  logic                    is_br_q, is_br_d;
  branch_op_e              br_op_q, br_op_d;

  vec_t cur_vec, nxt_vec;
  logic mismatch, stop_run;

  assign cur_vec  = vec_at(idx_q);
  assign nxt_vec  = vec_at(idx_q + 4'd1);
  // 4-state compare so X/Z from a broken ALU counts as a failure
  assign mismatch = (alu_result_i !== cur_vec.exp_res) || (alu_branch_true_i !== cur_vec.exp_br);

`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
  assign stop_run = (idx_q == IDX_LAST) || mismatch;
`else
  assign stop_run = (idx_q == IDX_LAST);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    op_d    = op_q;
    is_br_d = is_br_q;
    br_op_d = br_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_APPLY;
          idx_d   = 4'd0;
          cnt_d   = CNT_INIT;
          fail_d  = '0;
          ffi_d   = IDX_NONE;
          pass_d  = 1'b0;
          src_a_d = vec_at(4'd0).a;
          src_b_d = vec_at(4'd0).b;
          op_d    = vec_at(4'd0).op;
          is_br_d = vec_at(4'd0).is_br;
          br_op_d = vec_at(4'd0).br_op;
        end
      end
      S_APPLY: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (fail_q != '1)     fail_d = fail_q + FAIL_ONE;
          if (ffi_q == IDX_NONE) ffi_d = idx_q;
        end
        if (stop_run) begin
          // pass is resolved here so it is already valid while done_o pulses
          state_d = S_DONE;
          pass_d  = (fail_d == '0);
          src_a_d = '0;
          src_b_d = '0;
          op_d    = ALU_ADD;
          is_br_d = 1'b0;
          br_op_d = BR_EQ;
        end else begin
          state_d = S_APPLY;
          idx_d   = idx_q + 4'd1;
          cnt_d   = CNT_INIT;
          src_a_d = nxt_vec.a;
          src_b_d = nxt_vec.b;
          op_d    = nxt_vec.op;
          is_br_d = nxt_vec.is_br;
          br_op_d = nxt_vec.br_op;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      fail_q  <= '0;
      ffi_q   <= IDX_NONE;
      pass_q  <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      op_q    <= ALU_ADD;
      is_br_q <= 1'b0;
      br_op_q <= BR_EQ;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      op_q    <= op_d;
      is_br_q <= is_br_d;
      br_op_q <= br_op_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign fail_count_o     = fail_q;
  assign first_fail_idx_o = ffi_q;
  assign src_a_o          = src_a_q;
  assign src_b_o          = src_b_q;
  assign alu_control_o    = op_q;
  assign is_branch_o      = is_br_q;
  assign branch_op_o      = br_op_q;

endmodule
